// File: rtl/io_cell_cfg_pkg.sv
// -----------------------------------------------------------------------------
// io_cell_cfg_pkg
// Shared constants for the IO cell configuration register bank: APB register
// map, CTRL/STATUS bit positions and the default cell geometry that is also
// used by the IO cell frame.
// -----------------------------------------------------------------------------
package io_cell_cfg_pkg;

  // Default cell geometry (shared with the IO cell frame)
  localparam int unsigned DEF_IOCELL_CFG_W = 5;
  localparam int unsigned DEF_IOCELL_COUNT = 25;

  // APB bus widths
  localparam int unsigned APB_AW = 12;
  localparam int unsigned APB_DW = 32;

  // Register map (byte addresses)
  localparam logic [APB_AW-1:0] CELL_BASE   = 12'h000;
  localparam logic [APB_AW-1:0] CTRL_ADDR   = 12'h080;
  localparam logic [APB_AW-1:0] STATUS_ADDR = 12'h084;

  // CTRL bit indices
  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_LOCK_BIT   = 1;

  // STATUS bit indices
  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned STATUS_LOCKED_BIT  = 1;

  // Word index of a byte address; the two byte-lane bits are ignored.
  function automatic logic [APB_AW-3:0] word_of(input logic [APB_AW-1:0] addr);
    return addr[APB_AW-1:2];
  endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// -----------------------------------------------------------------------------
// apb_reg_decode
// Pure combinational address decode for the IO cell configuration bank.
// Ports:
//   i_addr       APB byte address (bits [1:0] ignored)
//   o_cell_idx   cell index addressed (valid when o_cell_hit)
//   o_cell_hit   address falls on an implemented CELL[i] register
//   o_ctrl_hit   address is CTRL
//   o_status_hit address is STATUS
//   o_err        address is unmapped
// -----------------------------------------------------------------------------
module apb_reg_decode
  import io_cell_cfg_pkg::*;
#(
  parameter int unsigned CELL_COUNT = DEF_IOCELL_COUNT
) (
  input  logic [APB_AW-1:0] i_addr,
  output logic [4:0]        o_cell_idx,
  output logic              o_cell_hit,
  output logic              o_ctrl_hit,
  output logic              o_status_hit,
  output logic              o_err
);

  logic [APB_AW-3:0] w_word;
  logic              w_unused_lanes;

  // Byte-lane bits carry no information for word registers.
  assign w_unused_lanes = &{1'b0, i_addr[1:0]};

  // Classify the address into cell / ctrl / status / unmapped.
  always_comb begin
    w_word       = word_of(i_addr) - word_of(CELL_BASE);
    o_cell_idx   = w_word[4:0];
    o_cell_hit   = ({22'd0, w_word} < CELL_COUNT);
    o_ctrl_hit   = (word_of(i_addr) == word_of(CTRL_ADDR));
    o_status_hit = (word_of(i_addr) == word_of(STATUS_ADDR));
    o_err        = !(o_cell_hit || o_ctrl_hit || o_status_hit);
  end

endmodule

// File: rtl/io_cell_cfg_regs.sv
// -----------------------------------------------------------------------------
// io_cell_cfg_regs
// APB3 register bank producing the per-pad configuration vector for the IO
// cell frame. Software writes shadow registers and applies them all at once
// with a COMMIT so the pads never see a half-updated configuration. A sticky
// LOCK freezes shadow writes and commits until reset.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   PADDR..PWDATA     APB3 request
//   PRDATA, PREADY,
//   PSLVERR           APB3 response (zero wait states)
//   cell_cfg          active configuration, cell i at [(i+1)*W-1 : i*W]
//   cfg_updated       one-cycle pulse after each accepted commit
// -----------------------------------------------------------------------------
module io_cell_cfg_regs
  import io_cell_cfg_pkg::*;
#(
  parameter int unsigned              IOCELL_CFG_W   = DEF_IOCELL_CFG_W,
  parameter int unsigned              IOCELL_COUNT   = DEF_IOCELL_COUNT,
  parameter logic [IOCELL_CFG_W-1:0]  IOCELL_CFG_RST = {IOCELL_CFG_W{1'b0}}
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [APB_AW-1:0]                    PADDR,
  input  logic                                 PSEL,
  input  logic                                 PENABLE,
  input  logic                                 PWRITE,
  input  logic [APB_DW-1:0]                    PWDATA,
  output logic [APB_DW-1:0]                    PRDATA,
  output logic                                 PREADY,
  output logic                                 PSLVERR,
  output logic [IOCELL_CFG_W*IOCELL_COUNT-1:0] cell_cfg,
  output logic                                 cfg_updated
);

  logic [IOCELL_COUNT-1:0][IOCELL_CFG_W-1:0] r_shadow;
  logic [IOCELL_COUNT-1:0][IOCELL_CFG_W-1:0] r_active;
  logic                                      r_lock;
  logic                                      r_cfg_updated;

  logic [4:0]              w_cell_idx;
  logic                    w_cell_hit;
  logic                    w_ctrl_hit;
  logic                    w_status_hit;
  logic                    w_addr_err;
  logic                    w_access;
  logic                    w_wr;
  logic                    w_cell_wr;
  logic                    w_commit;
  logic                    w_lock_set;
  logic                    w_pending;
  logic [IOCELL_CFG_W-1:0] w_cell_rd;
  logic [APB_DW-1:0]       w_prdata;
  logic                    w_pslverr;
  logic                    w_unused_wdata;

  apb_reg_decode #(
    .CELL_COUNT (IOCELL_COUNT)
  ) u_decode (
    .i_addr       (PADDR),
    .o_cell_idx   (w_cell_idx),
    .o_cell_hit   (w_cell_hit),
    .o_ctrl_hit   (w_ctrl_hit),
    .o_status_hit (w_status_hit),
    .o_err        (w_addr_err)
  );

  // Upper write-data bits are don't-care for every register.
  assign w_unused_wdata = &{1'b0, PWDATA[APB_DW-1:IOCELL_CFG_W]};

  assign w_access  = PSEL & PENABLE;
  assign w_wr      = w_access & PWRITE;
  // Lock blocks shadow writes and commits; a commit+lock pair commits first
  // because w_commit looks at the lock value before this edge.
  assign w_cell_wr  = w_wr & w_cell_hit & ~r_lock;
  assign w_commit   = w_wr & w_ctrl_hit & PWDATA[CTRL_COMMIT_BIT] & ~r_lock;
  assign w_lock_set = w_wr & w_ctrl_hit & PWDATA[CTRL_LOCK_BIT];
  assign w_pending  = (r_shadow != r_active);

  // Shadow copies written by software.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IOCELL_COUNT; i++) begin
        r_shadow[i] <= IOCELL_CFG_RST;
      end
    end else begin
      for (int i = 0; i < IOCELL_COUNT; i++) begin
        if (w_cell_wr && (w_cell_idx == i[4:0])) begin
          r_shadow[i] <= PWDATA[IOCELL_CFG_W-1:0];
        end
      end
    end
  end

  // Active configuration: all cells loaded together on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IOCELL_COUNT; i++) begin
        r_active[i] <= IOCELL_CFG_RST;
      end
    end else if (w_commit) begin
      r_active <= r_shadow;
    end
  end

  // Sticky lock and the post-commit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock        <= 1'b0;
      r_cfg_updated <= 1'b0;
    end else begin
      r_cfg_updated <= w_commit;
      if (w_lock_set) begin
        r_lock <= 1'b1;
      end
    end
  end

  // Shadow read mux over the addressed cell.
  always_comb begin
    w_cell_rd = {IOCELL_CFG_W{1'b0}};
    for (int i = 0; i < IOCELL_COUNT; i++) begin
      if (w_cell_idx == i[4:0]) begin
        w_cell_rd = r_shadow[i];
      end else begin
        w_cell_rd = w_cell_rd;
      end
    end
  end

  // APB response; data and error are only driven during the access phase.
  always_comb begin
    w_prdata  = {APB_DW{1'b0}};
    w_pslverr = 1'b0;
    if (w_access) begin
      if (w_addr_err) begin
        w_pslverr = 1'b1;
      end else if (w_cell_hit) begin
        if (PWRITE) begin
          w_pslverr = r_lock;
        end else begin
          w_prdata[IOCELL_CFG_W-1:0] = w_cell_rd;
        end
      end else if (w_ctrl_hit) begin
        if (PWRITE) begin
          w_pslverr = r_lock & PWDATA[CTRL_COMMIT_BIT];
        end else begin
          w_prdata[CTRL_LOCK_BIT] = r_lock;
        end
      end else begin
        if (PWRITE) begin
          w_pslverr = 1'b1;
        end else begin
          w_prdata[STATUS_PENDING_BIT] = w_pending;
          w_prdata[STATUS_LOCKED_BIT]  = r_lock;
        end
      end
    end else begin
      w_prdata  = {APB_DW{1'b0}};
      w_pslverr = 1'b0;
    end
  end

  assign PRDATA      = w_prdata;
  assign PSLVERR     = w_pslverr;
  assign PREADY      = w_access;
  assign cell_cfg    = r_active;
  assign cfg_updated = r_cfg_updated;

endmodule

// File: tb/tb_io_cell_cfg_regs.sv
module tb_io_cell_cfg_regs;

  localparam int NCELL = 25;
  localparam int CW    = 5;
  localparam int VW    = NCELL * CW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [11:0]     PADDR = 12'd0;
  logic            PSEL = 1'b0;
  logic            PENABLE = 1'b0;
  logic            PWRITE = 1'b0;
  logic [31:0]     PWDATA = 32'd0;
  logic [31:0]     PRDATA;
  logic            PREADY;
  logic            PSLVERR;
  logic [VW-1:0]   cell_cfg;
  logic            cfg_updated;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [CW-1:0] m_sh  [NCELL];
  logic [CW-1:0] m_act [NCELL];
  logic          m_lock;

  io_cell_cfg_regs dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .cell_cfg    (cell_cfg),
    .cfg_updated (cfg_updated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCELL; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_lock = 1'b0;
  endtask

  function automatic logic [VW-1:0] model_cfg();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NCELL; i++) v[i*CW +: CW] = m_act[i];
    return v;
  endfunction

  function automatic logic model_pending();
    for (int i = 0; i < NCELL; i++) if (m_sh[i] != m_act[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Register behaviour at the level of the register map.
  task automatic model_access(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err, output logic upd);
    int  a;
    logic was_locked;
    a = int'(addr) & 32'hFFC;
    rd = 32'd0; err = 1'b0; upd = 1'b0;
    was_locked = m_lock;
    if (a < 4 * NCELL) begin
      if (wr) begin
        if (was_locked) err = 1'b1;
        else m_sh[a/4] = wd[CW-1:0];
      end else begin
        rd = 32'(m_sh[a/4]);
      end
    end else if (a == 32'h080) begin
      if (wr) begin
        if (wd[0]) begin
          if (was_locked) err = 1'b1;
          else begin
            for (int i = 0; i < NCELL; i++) m_act[i] = m_sh[i];
            upd = 1'b1;
          end
        end
        if (wd[1]) m_lock = 1'b1;
      end else begin
        rd = {30'd0, m_lock, 1'b0};
      end
    end else if (a == 32'h084) begin
      if (wr) err = 1'b1;
      else rd = {30'd0, m_lock, model_pending()};
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic apb(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err, output logic rdy, output logic upd);
    @(negedge clk);
    PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    rd = PRDATA; err = PSLVERR; rdy = PREADY;
    @(posedge clk);
    #1;
    upd = cfg_updated;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic check_access(input logic [11:0] addr, input logic wr, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic err, eerr, rdy, upd, eupd;
    model_access(addr, wr, wd, erd, eerr, eupd);
    apb(addr, wr, wd, rd, err, rdy, upd);
    if (!wr) chk("prdata", rd, erd);
    chk("pslverr", err, eerr);
    chk("pready", rdy, 1);
    chk("cfg_updated", upd, eupd);
    chk("cell_cfg", cell_cfg, model_cfg());
    #1;
    chk("idle_outputs", {PREADY, PSLVERR, PRDATA}, 0);
  endtask

  task automatic do_reset();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cell_cfg", cell_cfg, 0);
    chk("rst_cfg_updated", cfg_updated, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [11:0]   addr;
    logic          wr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rd;
    logic          exp_err;
    logic          exp_upd;
    logic [VW-1:0] exp_cfg;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic [VW-1:0] c1, c2;
    logic [31:0]   rd;
    logic          err, rdy, upd;
    logic [11:0]   a;
    logic [31:0]   wd;
    logic          wr;

    model_reset();
    c1 = {{(VW-5){1'b0}}, 5'h1F} << 15;
    c2 = c1 | ({{(VW-5){1'b0}}, 5'h1F} << 120) | {{(VW-3){1'b0}}, 3'd5};

    vecs[0]  = '{12'h00C, 1'b1, 32'h1F,        32'h00, 1'b0, 1'b0, '0};
    vecs[1]  = '{12'h00C, 1'b0, 32'h0,         32'h1F, 1'b0, 1'b0, '0};
    vecs[2]  = '{12'h084, 1'b0, 32'h0,         32'h01, 1'b0, 1'b0, '0};
    vecs[3]  = '{12'h080, 1'b0, 32'h0,         32'h00, 1'b0, 1'b0, '0};
    vecs[4]  = '{12'h080, 1'b1, 32'h1,         32'h00, 1'b0, 1'b1, c1};
    vecs[5]  = '{12'h084, 1'b0, 32'h0,         32'h00, 1'b0, 1'b0, c1};
    vecs[6]  = '{12'h060, 1'b1, 32'hFFFF_FFFF, 32'h00, 1'b0, 1'b0, c1};
    vecs[7]  = '{12'h060, 1'b0, 32'h0,         32'h1F, 1'b0, 1'b0, c1};
    vecs[8]  = '{12'h064, 1'b0, 32'h0,         32'h00, 1'b1, 1'b0, c1};
    vecs[9]  = '{12'h064, 1'b1, 32'h5,         32'h00, 1'b1, 1'b0, c1};
    vecs[10] = '{12'h0F0, 1'b0, 32'h0,         32'h00, 1'b1, 1'b0, c1};
    vecs[11] = '{12'h084, 1'b1, 32'h3,         32'h00, 1'b1, 1'b0, c1};
    vecs[12] = '{12'h084, 1'b0, 32'h0,         32'h01, 1'b0, 1'b0, c1};
    vecs[13] = '{12'h000, 1'b1, 32'h5,         32'h00, 1'b0, 1'b0, c1};
    vecs[14] = '{12'h080, 1'b1, 32'h3,         32'h00, 1'b0, 1'b1, c2};
    vecs[15] = '{12'h084, 1'b0, 32'h0,         32'h02, 1'b0, 1'b0, c2};
    vecs[16] = '{12'h000, 1'b1, 32'h7,         32'h00, 1'b1, 1'b0, c2};
    vecs[17] = '{12'h000, 1'b0, 32'h0,         32'h05, 1'b0, 1'b0, c2};
    vecs[18] = '{12'h080, 1'b1, 32'h1,         32'h00, 1'b1, 1'b0, c2};
    vecs[19] = '{12'h080, 1'b1, 32'h2,         32'h00, 1'b0, 1'b0, c2};
    vecs[20] = '{12'h080, 1'b0, 32'h0,         32'h02, 1'b0, 1'b0, c2};

    // Reset state
    #3;
    chk("reset_prdata", PRDATA, 0);
    chk("reset_pready", PREADY, 0);
    chk("reset_pslverr", PSLVERR, 0);
    chk("reset_cell_cfg", cell_cfg, 0);
    chk("reset_cfg_updated", cfg_updated, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NCELL; i++) check_access(12'(4 * i), 1'b0, 32'd0);
    check_access(12'h084, 1'b0, 32'd0);

    // Directed register-map walk
    for (int i = 0; i < 21; i++) begin
      apb(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, err, rdy, upd);
      if (!vecs[i].wr) chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_pslverr", i), err, vecs[i].exp_err);
      chk($sformatf("vec%0d_pready", i), rdy, 1);
      chk($sformatf("vec%0d_cfg_updated", i), upd, vecs[i].exp_upd);
      chk($sformatf("vec%0d_cell_cfg", i), cell_cfg, vecs[i].exp_cfg);
    end

    // Reset clears lock and the active configuration
    do_reset();
    check_access(12'h084, 1'b0, 32'd0);

    // Reset asserted in the access phase of a commit aborts it
    check_access(12'h008, 1'b1, 32'h3);
    check_access(12'h080, 1'b1, 32'h1);
    check_access(12'h004, 1'b1, 32'hA);
    @(negedge clk);
    PADDR = 12'h080; PWRITE = 1'b1; PWDATA = 32'h1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cell_cfg_async", cell_cfg, 0);
    chk("abort_cfg_updated_async", cfg_updated, 0);
    @(posedge clk);
    #1;
    chk("abort_cell_cfg_after_edge", cell_cfg, 0);
    chk("abort_cfg_updated_after_edge", cfg_updated, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_access(12'h004, 1'b0, 32'd0);
    check_access(12'h084, 1'b0, 32'd0);

    // Back-to-back commits with nothing pending
    check_access(12'h008, 1'b1, 32'h9);
    check_access(12'h080, 1'b1, 32'h1);
    check_access(12'h080, 1'b1, 32'h1);
    check_access(12'h080, 1'b1, 32'h1);
    @(posedge clk);
    #1;
    chk("b2b_pulse_width", cfg_updated, 0);
    chk("b2b_cell_cfg_stable", cell_cfg, model_cfg());

    // Randomized traffic against the model, in two reset epochs
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int n = 0; n < 250; n++) begin
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: a = 12'(4 * $urandom_range(0, NCELL - 1)) | 12'($urandom_range(0, 3));
          6: begin
            a  = 12'h080 | 12'($urandom_range(0, 3));
            wd[1] = ($urandom_range(0, 29) == 0);
          end
          7: a = 12'h084;
          8: a = 12'(4 * $urandom_range(NCELL, 31));
          default: a = 12'($urandom_range(0, 4095));
        endcase
        if (a[11:2] == 10'h020) wd[1] = ($urandom_range(0, 29) == 0);
        check_access(a, wr, wd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
